// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data + odd parity, stop, ACK sampling.
// Fall-driven; data changes only while the device holds the clock low; start and transfer timeouts abort to ERR.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC  = 5000,
  parameter int unsigned START_TO_CYC = 750000,
  parameter int unsigned XFER_TO_CYC  = 100000,
  parameter int unsigned FILT_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_STOP, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   tmr_q, tmr_d;
  logic [31:0]   xfer_q, xfer_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    sh_q, sh_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic [1:0]    code_q, code_d;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          xfer_exp;

  // The filtered clock only follows the synced pad after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_i;
      data_s2 <= data_s1;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall     = clk_filt && !clk_s2 && (filt_cnt == FW'(FILT_LEN - 1));
  assign xfer_exp = (xfer_q == XFER_TO_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      xfer_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      xfer_q    <= xfer_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      code_q    <= code_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 32'd1;
    xfer_d    = xfer_q + 32'd1;
    bit_d     = bit_q;
    sh_d      = sh_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    code_d    = code_q;
    case (state_q)
      S_IDLE: begin
        tmr_d     = '0;
        xfer_d    = '0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          sh_d    = {~^tx_data, tx_data};
          ack_d   = 1'b0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr_q == INHIBIT_CYC - 1) begin
          tmr_d     = '0;
          bit_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (fall) begin
          data_oe_d = ~sh_q[0];
          sh_d      = {1'b1, sh_q[8:1]};
          bit_d     = 4'd1;
          xfer_d    = '0;
          state_d   = S_SHIFT;
        end else if (tmr_q == START_TO_CYC - 1) begin
          code_d    = 2'b01;
          data_oe_d = 1'b0;
          state_d   = S_ERR;
        end
      end
      S_SHIFT: begin
        if (xfer_exp) begin
          code_d    = 2'b10;
          data_oe_d = 1'b0;
          state_d   = S_ERR;
        end else if (fall) begin
          // Parity sits in sh_q[0] after eight shifts, so fall 9 (bit_q == 8) sends it.
          data_oe_d = ~sh_q[0];
          sh_d      = {1'b1, sh_q[8:1]};
          bit_d     = bit_q + 4'd1;
          if (bit_q == 4'd8) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (xfer_exp) begin
          code_d    = 2'b10;
          data_oe_d = 1'b0;
          state_d   = S_ERR;
        end else if (fall) begin
          data_oe_d = 1'b0;
          bit_d     = bit_q + 4'd1;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (xfer_exp) begin
          code_d  = 2'b10;
          state_d = S_ERR;
        end else if (fall) begin
          ack_d   = ~data_s2;
          bit_d   = bit_q + 4'd1;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (xfer_exp) begin
          code_d  = 2'b10;
          state_d = S_ERR;
        end else if (clk_filt && data_s2) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rx_inhibit  = busy;
  assign done        = (state_q == S_DONE);
  assign ack_ok      = (state_q == S_DONE) && ack_q;
  assign error       = (state_q == S_ERR);
  assign err_code    = (state_q == S_ERR) ? code_q : 2'b00;
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  // Data goes low one cycle before the clock is released so the start bit is set up first.
  assign ps2_data_oe = data_oe_q || ((state_q == S_INHIBIT) && (tmr_q == INHIBIT_CYC - 1));

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model samples the frame; a scoreboard checks done/error pulses.
module tb_ps2_host_tx;
  localparam int INH   = 20;
  localparam int START = 300;
  localparam int XFER  = 1500;
  localparam int FILT  = 4;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       rst, tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, rx_inhibit, done, ack_ok, error;
  logic [1:0] err_code;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data, glitch_n;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int accept_cyc, last_evt_cyc, fall1_cyc, fall_cnt;
  int inhib_mis = 0;
  bit glitch_en, pulse_en, ready_chk_pending;

  logic [6:0] res_q[$];
  bit         bit_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ps2_clk_i  = ~ps2_clk_oe & dev_clk & glitch_n;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYC(INH), .START_TO_CYC(START), .XFER_TO_CYC(XFER), .FILT_LEN(FILT)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .rx_inhibit(rx_inhibit), .done(done), .ack_ok(ack_ok), .error(error),
    .err_code(err_code), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int val, input int lo, input int hi);
    n_chk++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // Frame layout {stop, parity, d7..d0, start}; the first nbits are pushed in wire order.
  task automatic send(input logic [7:0] d, input logic [10:0] frame, input int nbits,
                      input bit has_res, input logic [6:0] res);
    for (int i = 0; i < nbits; i++) bit_q.push_back(frame[i]);
    if (has_res) res_q.push_back(res);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    accept_cyc = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input int n_falls, input int n_samp, input bit do_ack);
    int t;
    t = 0;
    fall_cnt = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", (t < 5000), 1);
    if (t >= 5000) return;
    repeat (HALF) @(negedge clk);
    chk("frame_bit_start", ps2_data_i, (bit_q.size() > 0) ? bit_q.pop_front() : 1'b1);
    for (int k = 1; k <= n_falls; k++) begin
      if (k == 11 && do_ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      if (k == 1) fall1_cyc = cyc;
      fall_cnt = k;
      repeat (HALF) @(negedge clk);
      if (k <= n_samp && k <= 10) begin
        if (bit_q.size() == 0) chk($sformatf("frame_bit_%0d_extra", k), 1, 0);
        else chk($sformatf("frame_bit_%0d", k), ps2_data_i, bit_q.pop_front());
      end
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int t;
    t = 0;
    while ((res_q.size() != 0 || busy) && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drain"}, (t < limit), 1);
    chk({name, "_bits_left"}, bit_q.size(), 0);
  endtask

  // Result monitor: every done/error pulse must match the oldest expected record.
  initial begin
    logic [6:0] exp_r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy !== rx_inhibit) inhib_mis++;
        if (done || error) begin
          last_evt_cyc = cyc;
          ready_chk_pending = 1'b1;
          if (res_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: done=%b error=%b err_code=%b", done, error, err_code);
          end else begin
            exp_r = res_q.pop_front();
            chk("result", {done, ack_ok, error, err_code, ps2_clk_oe, ps2_data_oe}, exp_r);
          end
        end else if (ready_chk_pending) begin
          ready_chk_pending = 1'b0;
          chk("tx_ready_after_pulse", tx_ready, 1);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (glitch_en) begin
        repeat (13) @(negedge clk);
        glitch_n = 1'b0;
        @(negedge clk);
        glitch_n = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pulse_en && busy && !tx_valid) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (30) @(negedge clk);
      end
    end
  end

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1; glitch_n = 1'b1;
    glitch_en = 1'b0; pulse_en = 1'b0; ready_chk_pending = 1'b0;
    fall1_cyc = 0; fall_cnt = 0; accept_cyc = 0; last_evt_cyc = 0;
    repeat (5) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_inhibit", rx_inhibit, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_ok", ack_ok, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // T1: 0xED with ACK; parity 1
    fork
      send(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 11, 1'b1, 7'b1_1_0_00_00);
      dev_frame(11, 10, 1'b1);
    join
    wait_drain("t1", 3000);

    // T2: 0xF4 without ACK; parity 0
    fork
      send(8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, 11, 1'b1, 7'b1_0_0_00_00);
      dev_frame(11, 10, 1'b0);
    join
    wait_drain("t2", 3000);

    // T3: device silent -> start timeout
    send(8'h3C, 11'h000, 0, 1'b1, 7'b0_0_1_01_00);
    wait_drain("t3", INH + START + 200);
    chk_range("start_to_time", last_evt_cyc - accept_cyc, INH + START - 2, INH + START + 2);

    // T4: device stops after fall 5 -> transfer timeout measured from fall 1
    fork
      send(8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}, 6, 1'b1, 7'b0_0_1_10_00);
      dev_frame(5, 5, 1'b0);
    join
    wait_drain("t4", XFER + 500);
    chk_range("xfer_to_time", last_evt_cyc - fall1_cyc, XFER, XFER + FILT + 4);

    // T5: reset during fall 4, then a clean 0x55
    fall_cnt = 0;
    fork
      send(8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 4, 1'b0, 7'b0);
      dev_frame(4, 3, 1'b0);
      begin
        int t;
        t = 0;
        while (fall_cnt < 4 && t < 3000) begin
          @(negedge clk);
          t++;
        end
        chk("t5_fall4_seen", (t < 3000), 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_clk_oe", ps2_clk_oe, 0);
        chk("t5_data_oe", ps2_data_oe, 0);
        chk("t5_tx_ready", tx_ready, 1);
        chk("t5_busy", busy, 0);
        rst = 1'b0;
      end
    join
    wait_drain("t5", 500);
    fork
      send(8'h55, {1'b1, 1'b1, 8'h55, 1'b0}, 11, 1'b1, 7'b1_1_0_00_00);
      dev_frame(11, 10, 1'b1);
    join
    wait_drain("t5b", 3000);

    // T6: clock glitches and tx_valid pulses while busy, 0xF3 with ACK
    glitch_en = 1'b1;
    pulse_en  = 1'b1;
    fork
      send(8'hF3, {1'b1, 1'b1, 8'hF3, 1'b0}, 11, 1'b1, 7'b1_1_0_00_00);
      dev_frame(11, 10, 1'b1);
    join
    wait_drain("t6", 3000);
    glitch_en = 1'b0;
    pulse_en  = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_no_second_frame", busy, 0);
    chk("busy_eq_rx_inhibit", inhib_mis, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
